// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// Op encodings follow the RISC-V M-extension funct3 field.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic wants_high(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration: BPC shift-add or restore-subtract steps on {hi, lo}.
// Multiply keeps the multiplier in lo; divide keeps the dividend/quotient in lo.
module muldiv_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic                div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    always_comb begin
        logic [2*XLEN-1:0] cur;
        logic [XLEN:0]     rem_sh;
        logic [XLEN:0]     sum;
        logic [XLEN-1:0]   diff;
        logic              ge;
        cur = acc_in;
        for (int i = 0; i < BPC; i++) begin
            rem_sh = {cur[2*XLEN-1:XLEN], cur[XLEN-1]};
            ge     = rem_sh >= {1'b0, operand};
            diff   = rem_sh[XLEN-1:0] - operand;
            sum    = {1'b0, cur[2*XLEN-1:XLEN]}
                   + (cur[0] ? {1'b0, operand} : '0);
            // remainder stays below the divisor, so diff always fits XLEN bits
            if (div)
                cur = {(ge ? diff : rem_sh[XLEN-1:0]), cur[XLEN-2:0], ge};
            else
                cur = {sum, cur[XLEN-1:1]};
        end
        acc_out = cur;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit beside the ALU.
// Works on operand magnitudes and applies the sign correction at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int STEPS = XLEN / BPC;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(STEPS - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = '1;

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor;
    muldiv_op_e        op_q;
    logic              neg_q;

    muldiv_op_e        op_in;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   fast_res;
    logic              neg_in;

    logic              div_q;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dval;
    logic [XLEN-1:0]   res_nxt;

    assign op_in    = muldiv_op_e'(op);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign div_q    = is_div(op_q);

    always_comb begin
        sign_a   = is_signed_a(op_in) & a[XLEN-1];
        sign_b   = is_signed_b(op_in) & b[XLEN-1];
        mag_a    = sign_a ? -a : a;
        mag_b    = sign_b ? -b : b;
        div_zero = is_div(op_in) && (b == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                && (a == MIN_INT) && (b == ONES);
        neg_in   = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
        fast_res = '0;
        unique case (1'b1)
            div_zero: fast_res = is_rem(op_in) ? a : ONES;
            div_ovf:  fast_res = is_rem(op_in) ? '0 : MIN_INT;
            default:  fast_res = '0;
        endcase
    end

    muldiv_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .div     (div_q),
        .acc_in  (acc),
        .operand (divisor),
        .acc_out (acc_nxt)
    );

    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        dval = is_rem(op_q) ? acc_nxt[2*XLEN-1:XLEN]
                            : acc_nxt[XLEN-1:0];
        if (div_q)
            res_nxt = neg_q ? -dval : dval;
        else if (wants_high(op_q))
            res_nxt = prod[2*XLEN-1:XLEN];
        else
            res_nxt = prod[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            divisor   <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_in;
                        neg_q   <= neg_in;
                        divisor <= mag_b;
                        acc     <= {{XLEN{1'b0}}, mag_a};
                        cnt     <= '0;
                        if (div_zero || div_ovf) begin
                            result    <= fast_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            result    <= res_nxt;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // kill takes priority over a same-cycle handshake
                    if (kill || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
